// File: rtl/vga_pkg.sv
// Shared raster-timing definitions for the video pipeline.
// Default values describe 640x480@60 with a 25.175 MHz pixel clock.
package vga_pkg;

  localparam int unsigned COORD_W   = 11;
  localparam int unsigned MAX_TOTAL = 2048;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;

  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  // Pixels per line, blanking included
  function automatic int unsigned calc_h_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // Lines per frame, blanking included
  function automatic int unsigned calc_v_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register that realigns sync/de with registered pixel data.
module sync_delay #(
  parameter int unsigned      WIDTH     = 1,
  parameter int unsigned      DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift every clock; reset flushes every stage to the idle value
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESET_VAL;
      end
    end else begin
      stage_q[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: pixel coordinates, vblank/frame strobes and
// pipeline-aligned hsync/vsync/de.
// Optional pixel-clock divider enabled by defining VGA_CLKDIV_EN.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0,
  parameter int unsigned PIPE_DELAY = 2,
  parameter int unsigned CLK_DIV    = 4
) (
  input  logic               clk,
  input  logic               rst,
  output logic               o_pix_en,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_vblank,
  output logic               o_frame_start,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_de
);

  localparam int unsigned H_TOTAL  = calc_h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL  = calc_v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  localparam logic [COORD_W-1:0] H_LAST_C   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST_C   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT_C    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT_C    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_START_C = COORD_W'(HS_START);
  localparam logic [COORD_W-1:0] HS_END_C   = COORD_W'(HS_END);
  localparam logic [COORD_W-1:0] VS_START_C = COORD_W'(VS_START);
  localparam logic [COORD_W-1:0] VS_END_C   = COORD_W'(VS_END);

  // Idle levels of {hsync, vsync, de}, also the flush value of the delay line
  localparam logic [2:0] SYNC_IDLE = {~HS_POL, ~VS_POL, 1'b0};

  // Refuse to elaborate a configuration the 11-bit counters or delay line cannot hold
  if ((H_TOTAL > MAX_TOTAL) || (V_TOTAL > MAX_TOTAL) ||
      (PIPE_DELAY < 1) || (PIPE_DELAY > 4) || (CLK_DIV < 2)) begin : g_bad_cfg
    $error("vga_timing: illegal timing parameters");
  end

  logic               pix_en;
  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic               raw_hs;
  logic               raw_vs;
  logic               raw_de;
  logic [2:0]         sync_q;

`ifdef VGA_CLKDIV_EN
  localparam int unsigned     DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  // Pixel-rate divider: one strobe on the last clock of each pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign pix_en = (div_cnt == DIV_LAST);
`else
  assign pix_en = 1'b1;
`endif

  // Horizontal/vertical raster counters, advanced once per pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST_C) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST_C) begin
          v_cnt <= '0;
        end else begin
          v_cnt <= v_cnt + COORD_W'(1);
        end
      end else begin
        h_cnt <= h_cnt + COORD_W'(1);
      end
    end
  end

  // Undelayed sync/de decoded from the current counter values
  always_comb begin
    raw_de = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    raw_hs = ((h_cnt >= HS_START_C) && (h_cnt < HS_END_C)) ? HS_POL : ~HS_POL;
    raw_vs = ((v_cnt >= VS_START_C) && (v_cnt < VS_END_C)) ? VS_POL : ~VS_POL;
  end

  sync_delay #(
    .WIDTH     (3),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk (clk),
    .rst (rst),
    .d   ({raw_hs, raw_vs, raw_de}),
    .q   (sync_q)
  );

  assign {o_hsync, o_vsync, o_de} = sync_q;

  assign o_pix_en = pix_en;
  assign o_x      = h_cnt;
  assign o_y      = v_cnt;
  assign o_vblank = (v_cnt >= V_ACT_C);

  // Held low during reset so the origin strobe is a single clock once running
  assign o_frame_start = pix_en && !rst && (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing using a reduced raster (70x15 totals).
module tb_vga_timing;

  localparam int HA = 40, HF = 8, HS = 12, HB = 10;
  localparam int VA = 8,  VF = 2, VS = 2,  VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int PD = 2;
`ifdef VGA_CLKDIV_EN
  localparam int D = 4;
`else
  localparam int D = 1;
`endif
  localparam int LINE_CLK  = HT * D;
  localparam int FRAME_CLK = FRAME * D;

  typedef struct packed {
    logic        pix_en;
    logic [10:0] x;
    logic [10:0] y;
    logic        vblank;
    logic        fs;
    logic        hs;
    logic        vs;
    logic        de;
  } out_t;

  typedef struct {
    int px;
    int x;
    int y;
    bit vb;
    bit de;
    bit hs;
    bit vs;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_en, vblank, frame_start, hsync, vsync, de;
  logic [10:0] x, y;

  int n_cmp = 0;
  int n_bad = 0;
  int t = 0;
  int de_start = -1, hs_start = -1, vs_start = -1, last_fs = -1;
  int n_de_runs = 0, n_hs_runs = 0, n_vs_runs = 0, n_fs_pairs = 0;
  bit prev_de = 1'b0, prev_hs = 1'b1, prev_vs = 1'b1, prev_fs = 1'b0;
  out_t sb_q[$];
  vec_t vec[16];

  vga_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DELAY(PD), .CLK_DIV(4)
  ) dut (
    .clk(clk), .rst(rst), .o_pix_en(pix_en), .o_x(x), .o_y(y),
    .o_vblank(vblank), .o_frame_start(frame_start),
    .o_hsync(hsync), .o_vsync(vsync), .o_de(de)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at t=%0d", t);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0d)", name, act, exp, t);
    end
  endtask

  function automatic out_t sample();
    out_t a;
    a.pix_en = pix_en; a.x = x; a.y = y; a.vblank = vblank;
    a.fs = frame_start; a.hs = hsync; a.vs = vsync; a.de = de;
    return a;
  endfunction

  // Closed-form expectation from clocks elapsed since the last reset edge
  function automatic out_t model(input int tt, input bit r);
    out_t e;
    int n, nd, hx, vy;
    e.pix_en = ((tt % D) == D - 1);
    n = (tt / D) % FRAME;
    e.x = 11'(n % HT);
    e.y = 11'(n / HT);
    e.vblank = (n / HT) >= VA;
    e.fs = e.pix_en && (n == 0) && !r;
    if (tt < PD) begin
      e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0;
    end else begin
      nd = ((tt - PD) / D) % FRAME;
      hx = nd % HT;
      vy = nd / HT;
      e.de = (hx < HA) && (vy < VA);
      e.hs = !((hx >= HA + HF) && (hx < HA + HF + HS));
      e.vs = !((vy >= VA + VF) && (vy < VA + VF + VS));
    end
    return e;
  endfunction

  task automatic track(input out_t a, input bit r);
    if (r) begin
      de_start = -1; hs_start = -1; vs_start = -1; last_fs = -1;
    end else begin
      if (a.de && !prev_de) begin
        chk("de_rise_phase", t % LINE_CLK, PD);
        de_start = t;
      end
      if (!a.de && prev_de && de_start >= 0) begin
        chk("de_width", t - de_start, HA * D);
        n_de_runs++;
      end
      if (!a.hs && prev_hs) begin
        chk("hsync_fall_phase", t % LINE_CLK, (HA + HF) * D + PD);
        hs_start = t;
      end
      if (a.hs && !prev_hs && hs_start >= 0) begin
        chk("hsync_width", t - hs_start, HS * D);
        n_hs_runs++;
      end
      if (!a.vs && prev_vs) begin
        chk("vsync_fall_phase", t % FRAME_CLK, (VA + VF) * HT * D + PD);
        vs_start = t;
      end
      if (a.vs && !prev_vs && vs_start >= 0) begin
        chk("vsync_width", t - vs_start, VS * HT * D);
        n_vs_runs++;
      end
      if (a.fs) begin
        chk("fs_width", 32'(prev_fs), 0);
        if (last_fs >= 0) begin
          chk("fs_period", t - last_fs, FRAME_CLK);
          n_fs_pairs++;
        end
        last_fs = t;
      end
    end
    chk("de_in_vblank", 32'(a.de & a.vblank), 0);
    prev_de = a.de; prev_hs = a.hs; prev_vs = a.vs; prev_fs = a.fs;
  endtask

  // Drive rst for the coming edge, queue the expectation, then check it
  task automatic tick(input bit r);
    out_t a, e;
    rst = r;
    t = r ? 0 : t + 1;
    sb_q.push_back(model(t, r));
    @(posedge clk);
    #1;
    a = sample();
    e = sb_q.pop_front();
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL scoreboard t=%0d: got pe=%0b x=%0d y=%0d vb=%0b fs=%0b hs=%0b vs=%0b de=%0b, want pe=%0b x=%0d y=%0d vb=%0b fs=%0b hs=%0b vs=%0b de=%0b",
               t, a.pix_en, a.x, a.y, a.vblank, a.fs, a.hs, a.vs, a.de,
               e.pix_en, e.x, e.y, e.vblank, e.fs, e.hs, e.vs, e.de);
    end
    track(a, r);
  endtask

  task automatic run_to(input int target);
    while (t < target) tick(1'b0);
  endtask

  initial begin
    vec[0]  = '{px: 0,    x: 0,  y: 0,  vb: 0, de: 1, hs: 1, vs: 1};
    vec[1]  = '{px: 39,   x: 39, y: 0,  vb: 0, de: 1, hs: 1, vs: 1};
    vec[2]  = '{px: 41,   x: 41, y: 0,  vb: 0, de: 0, hs: 1, vs: 1};
    vec[3]  = '{px: 47,   x: 47, y: 0,  vb: 0, de: 0, hs: 1, vs: 1};
    vec[4]  = '{px: 49,   x: 49, y: 0,  vb: 0, de: 0, hs: 0, vs: 1};
    vec[5]  = '{px: 59,   x: 59, y: 0,  vb: 0, de: 0, hs: 0, vs: 1};
    vec[6]  = '{px: 61,   x: 61, y: 0,  vb: 0, de: 0, hs: 1, vs: 1};
    vec[7]  = '{px: 69,   x: 69, y: 0,  vb: 0, de: 0, hs: 1, vs: 1};
    vec[8]  = '{px: 71,   x: 1,  y: 1,  vb: 0, de: 1, hs: 1, vs: 1};
    vec[9]  = '{px: 529,  x: 39, y: 7,  vb: 0, de: 1, hs: 1, vs: 1};
    vec[10] = '{px: 560,  x: 0,  y: 8,  vb: 1, de: 0, hs: 1, vs: 1};
    vec[11] = '{px: 700,  x: 0,  y: 10, vb: 1, de: 0, hs: 1, vs: 0};
    vec[12] = '{px: 820,  x: 50, y: 11, vb: 1, de: 0, hs: 0, vs: 0};
    vec[13] = '{px: 840,  x: 0,  y: 12, vb: 1, de: 0, hs: 1, vs: 1};
    vec[14] = '{px: 1048, x: 68, y: 14, vb: 1, de: 0, hs: 1, vs: 1};
    vec[15] = '{px: 1050, x: 0,  y: 0,  vb: 0, de: 1, hs: 1, vs: 1};

    // Reset held for three clocks
    for (int i = 0; i < 3; i++) tick(1'b1);
    chk("rst_x", 32'(x), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_hsync", 32'(hsync), 1);
    chk("rst_vsync", 32'(vsync), 1);
    chk("rst_de", 32'(de), 0);
    chk("rst_frame_start", 32'(frame_start), 0);
    chk("rst_pix_en", 32'(pix_en), 32'(D == 1));

    // Release: first frame begins at origin outside vblank
    rst = 1'b0;
    #1;
    chk("release_vblank", 32'(vblank), 0);
    chk("release_frame_start", 32'(frame_start), 32'(D == 1));

    // Table of checkpoints through the first frame and its wrap
    for (int i = 0; i < 16; i++) begin
      run_to(vec[i].px * D);
      chk($sformatf("vec%0d_x", i), 32'(x), vec[i].x);
      chk($sformatf("vec%0d_y", i), 32'(y), vec[i].y);
      chk($sformatf("vec%0d_vblank", i), 32'(vblank), 32'(vec[i].vb));
      run_to(vec[i].px * D + PD);
      chk($sformatf("vec%0d_de", i), 32'(de), 32'(vec[i].de));
      chk($sformatf("vec%0d_hsync", i), 32'(hsync), 32'(vec[i].hs));
      chk($sformatf("vec%0d_vsync", i), 32'(vsync), 32'(vec[i].vs));
    end

    // Frame wrap from the last pixel of frame 1
    run_to(2 * FRAME_CLK - 1);
    chk("wrap_pre_x", 32'(x), HT - 1);
    chk("wrap_pre_y", 32'(y), VT - 1);
    tick(1'b0);
    chk("wrap_x", 32'(x), 0);
    chk("wrap_y", 32'(y), 0);
    chk("wrap_frame_start", 32'(frame_start), 32'(D == 1));
    tick(1'b0);
    chk("wrap_frame_start_next", 32'(frame_start), 0);

    // One-clock reset in the middle of a visible line
    run_to(2 * FRAME_CLK + (5 * HT + 30) * D);
    chk("mid_pre_x", 32'(x), 30);
    chk("mid_pre_y", 32'(y), 5);
    tick(1'b1);
    chk("mid_x", 32'(x), 0);
    chk("mid_y", 32'(y), 0);
    chk("mid_de0", 32'(de), 0);
    chk("mid_hsync0", 32'(hsync), 1);
    tick(1'b0);
    chk("mid_de1", 32'(de), 0);
    chk("mid_hsync1", 32'(hsync), 1);
    tick(1'b0);
    chk("mid_de2", 32'(de), 1);

    // Run past the next frame origin after the mid-frame reset
    run_to(FRAME_CLK + 2 * LINE_CLK);

    chk("de_runs_seen", 32'(n_de_runs > 0), 1);
    chk("hsync_runs_seen", 32'(n_hs_runs > 0), 1);
    chk("vsync_runs_seen", 32'(n_vs_runs > 0), 1);
    chk("fs_pairs_seen", 32'(n_fs_pairs > 0), 1);
    chk("scoreboard_drained", 32'(sb_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
